key_fifo_writer: RTL



---
 rtl/key_fifo_writer_pkg.sv | 15 +
 rtl/key_fifo_writer_word_packer.sv | 29 ++
 rtl/key_fifo_writer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/key_fifo_writer_pkg.sv
// Shared constants and FSM encoding for the key FIFO producer; the hash engine
// reuses the width constants.
package key_fifo_writer_pkg;

    localparam int FIFOWIDTH      = 128;
    localparam int MAX_KEY_LEN    = 255;
    localparam int BYTES_PER_WORD = FIFOWIDTH / 8;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        WR_WORD = 2'd1,
        WR_LEN  = 2'd2
    } state_t;

endpackage

// File: rtl/key_fifo_writer_word_packer.sv
// Packs bytes MSB-first into a FIFO word by byte index; clr empties the word
// so unused bytes of a final partial word read as zero.
module key_fifo_writer_word_packer #(
    parameter int WIDTH = 128,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr,
    input  logic [IDX_W-1:0] idx,
    input  logic [7:0]       din,
    output logic [WIDTH-1:0] word
);

    localparam int BPW = WIDTH / 8;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            word <= '0;
        end else if (wr) begin
            for (int b = 0; b < BPW; b++) begin
                if (idx == IDX_W'(b))
                    word[WIDTH-1-8*b -: 8] <= din;
            end
        end
    end

endmodule

// File: rtl/key_fifo_writer.sv
// Byte-serial key stream to key / key-length FIFO writer.
// Optional KEYWR_STATS_EN adds key and word write counters.
module key_fifo_writer #(
    parameter int FIFOWIDTH   = key_fifo_writer_pkg::FIFOWIDTH,
    parameter int MAX_KEY_LEN = key_fifo_writer_pkg::MAX_KEY_LEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           iKeyByte,
    input  logic                 iKeyByteValid,
    input  logic                 iKeyByteLast,
    output logic                 oKeyByteReady,
    input  logic                 iWrKeyFull,
    input  logic                 iWrKeyLenFull,
    output logic                 oWrKeyFifo_en,
    output logic [FIFOWIDTH-1:0] oKey,
    output logic                 oWrKeyLenFifo_en,
    output logic [7:0]           oKeyLen,
    output logic                 oOversize
`ifdef KEYWR_STATS_EN
    ,
    output logic [31:0]          oKeyCount,
    output logic [31:0]          oWordCount
`endif
);

    import key_fifo_writer_pkg::*;

    localparam int BPW   = FIFOWIDTH / 8;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);
    localparam logic [7:0]       MAX_LEN8 = 8'(MAX_KEY_LEN);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx;
    logic [7:0]       len_cnt;
    logic             key_end;
    logic             over;
    logic             xfer, keep, excess;
    logic             word_wr, len_wr;

    assign oKeyByteReady = (state == FILL) && !rst;
    assign xfer          = iKeyByteValid && oKeyByteReady;
    assign keep          = xfer && (len_cnt < MAX_LEN8);
    assign excess        = xfer && !keep;

    always_ff @(posedge clk) begin
        if (rst) state <= FILL;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        word_wr   = 1'b0;
        len_wr    = 1'b0;
        case (state)
            FILL: begin
                if (keep && (idx == LAST_IDX || iKeyByteLast))
                    state_nxt = WR_WORD;
                // excess bytes only flush a partial word left over at the limit
                else if (excess && iKeyByteLast)
                    state_nxt = (idx != '0) ? WR_WORD : WR_LEN;
            end
            WR_WORD: begin
                if (!iWrKeyFull) begin
                    word_wr   = 1'b1;
                    state_nxt = key_end ? WR_LEN : FILL;
                end
            end
            WR_LEN: begin
                if (!iWrKeyLenFull) begin
                    len_wr    = 1'b1;
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    assign oWrKeyFifo_en    = word_wr && !rst;
    assign oWrKeyLenFifo_en = len_wr && !rst;
    assign oKeyLen          = len_cnt;
    assign oOversize        = excess && !over;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            len_cnt <= '0;
            key_end <= 1'b0;
            over    <= 1'b0;
        end else begin
            if (keep) begin
                idx     <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
                len_cnt <= len_cnt + 8'd1;
                key_end <= iKeyByteLast;
            end
            if (excess) begin
                over    <= 1'b1;
                key_end <= iKeyByteLast;
            end
            if (word_wr)
                idx <= '0;
            if (len_wr) begin
                idx     <= '0;
                len_cnt <= '0;
                key_end <= 1'b0;
                over    <= 1'b0;
            end
        end
    end

    key_fifo_writer_word_packer #(
        .WIDTH (FIFOWIDTH),
        .IDX_W (IDX_W)
    ) u_packer (
        .clk  (clk),
        .rst  (rst),
        .clr  (word_wr),
        .wr   (keep),
        .idx  (idx),
        .din  (iKeyByte),
        .word (oKey)
    );

`ifdef KEYWR_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            oKeyCount  <= '0;
            oWordCount <= '0;
        end else begin
            if (oWrKeyLenFifo_en) oKeyCount  <= oKeyCount + 32'd1;
            if (oWrKeyFifo_en)    oWordCount <= oWordCount + 32'd1;
        end
    end
`endif

endmodule
